// File: rtl/rf_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rf_frame_sequencer
// Description : Buffers a framed valid/ready sample stream and replays it on
//               the range finder's go/finish/data protocol, then reports the
//               captured range, sample count and sticky error per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_frame_sequencer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic             s_ready,
    output logic [WIDTH-1:0] rf_data,
    output logic             rf_go,
    output logic             rf_finish,
    input  logic [WIDTH-1:0] rf_range,
    input  logic             rf_error,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_range,
    output logic             res_error,
    output logic [CNT_W-1:0] res_count
);

    localparam int               c_AW      = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_STREAM  = 2'd1;
    localparam logic [1:0] c_DUP     = 2'd2;
    localparam logic [1:0] c_CAPTURE = 2'd3;

    logic [WIDTH:0]   r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             r_rdy;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_err_seen;
    logic             r_cap_pend;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH:0]   w_head;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    // r_rdy keeps s_ready low while in reset and for the release edge
    assign s_ready = r_rdy && !w_full;
    assign w_push  = s_valid && s_ready;
    assign w_pop   = !w_empty && ((r_state == c_IDLE) || (r_state == c_STREAM));
    assign w_head  = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= {s_last, s_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy      <= 1'b0;
            r_state    <= c_IDLE;
            r_count    <= '0;
            r_err_seen <= 1'b0;
            r_cap_pend <= 1'b0;
            rf_data    <= '0;
            rf_go      <= 1'b0;
            rf_finish  <= 1'b0;
            res_valid  <= 1'b0;
            res_range  <= '0;
            res_error  <= 1'b0;
            res_count  <= '0;
        end else begin
            r_rdy      <= 1'b1;
            rf_go      <= 1'b0;
            rf_finish  <= 1'b0;
            res_valid  <= 1'b0;
            r_cap_pend <= 1'b0;

            // Result is taken one cycle after CAPTURE so rf_range has settled
            if (r_cap_pend) begin
                res_valid <= 1'b1;
                res_range <= rf_range;
                res_error <= r_err_seen | rf_error;
                res_count <= r_count;
            end

            case (r_state)
                c_IDLE: begin
                    if (w_pop) begin
                        rf_data    <= w_head[WIDTH-1:0];
                        rf_go      <= 1'b1;
                        r_count    <= c_CNT_ONE;
                        r_err_seen <= 1'b0;
                        r_state    <= w_head[WIDTH] ? c_DUP : c_STREAM;
                    end
                end
                c_STREAM: begin
                    if (rf_error) begin
                        r_err_seen <= 1'b1;
                    end
                    if (w_pop) begin
                        rf_data   <= w_head[WIDTH-1:0];
                        rf_finish <= w_head[WIDTH];
                        if (r_count != c_CNT_MAX) begin
                            r_count <= r_count + 1'b1;
                        end
                        if (w_head[WIDTH]) begin
                            r_state <= c_CAPTURE;
                        end
                    end
                end
                c_DUP: begin
                    if (rf_error) begin
                        r_err_seen <= 1'b1;
                    end
                    rf_finish <= 1'b1;
                    r_state   <= c_CAPTURE;
                end
                c_CAPTURE: begin
                    if (rf_error) begin
                        r_err_seen <= 1'b1;
                    end
                    r_cap_pend <= 1'b1;
                    r_state    <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_frame_sequencer
// Description : Bench for rf_frame_sequencer with a min/max range-finder model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_frame_sequencer;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_last;
    logic        s_ready;
    logic [15:0] rf_data;
    logic        rf_go;
    logic        rf_finish;
    logic [15:0] rf_range;
    logic        rf_error;
    logic        res_valid;
    logic [15:0] res_range;
    logic        res_error;
    logic [15:0] res_count;

    rf_frame_sequencer #(.WIDTH(16), .DEPTH(4), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .rf_data   (rf_data),
        .rf_go     (rf_go),
        .rf_finish (rf_finish),
        .rf_range  (rf_range),
        .rf_error  (rf_error),
        .res_valid (res_valid),
        .res_range (res_range),
        .res_error (res_error),
        .res_count (res_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Range finder: range = max - min of data from go through finish
    logic [15:0] rf_mn;
    logic [15:0] rf_mx;

    function automatic logic [15:0] fmin(input logic [15:0] a, input logic [15:0] b);
        return (a < b) ? a : b;
    endfunction
    function automatic logic [15:0] fmax(input logic [15:0] a, input logic [15:0] b);
        return (a > b) ? a : b;
    endfunction

    always @(posedge clk) begin
        if (rf_go) begin
            rf_mn <= rf_data;
            rf_mx <= rf_data;
        end else if (rf_finish) begin
            rf_range <= fmax(rf_mx, rf_data) - fmin(rf_mn, rf_data);
        end else begin
            rf_mn <= fmin(rf_mn, rf_data);
            rf_mx <= fmax(rf_mx, rf_data);
        end
    end

    typedef struct packed {
        logic [3:0]  gap;
        logic        last;
        logic [15:0] data;
    } smp_t;

    typedef struct packed {
        logic [15:0] rng;
        logic [15:0] cnt;
        logic        err;
        logic [15:0] first;
        logic [15:0] lst;
    } exp_t;

    typedef struct packed {
        logic [2:0]       n;
        logic [5:0][15:0] d;
        logic [5:0]       last;
        logic [5:0][3:0]  gap;
        logic [1:0]       err_frame;
        logic [1:0]       nres;
        logic [1:0][15:0] exp_range;
        logic [1:0][15:0] exp_cnt;
        logic [1:0]       exp_err;
    } vec_t;

    smp_t stim_q[$];
    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;
    int   stalls;

    task automatic chk(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic load_vec(input vec_t v);
        logic [15:0] ff [4];
        logic [15:0] fl [4];
        int          f;
        bit          start;
        smp_t        s;
        exp_t        e;
        stim_q.delete();
        exp_q.delete();
        f     = 0;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ff[i] = '0;
            fl[i] = '0;
        end
        for (int i = 0; i < int'(v.n); i++) begin
            s.gap  = v.gap[i];
            s.last = v.last[i];
            s.data = v.d[i];
            stim_q.push_back(s);
            if (start) ff[f] = v.d[i];
            start = v.last[i];
            if (v.last[i]) begin
                fl[f] = v.d[i];
                f++;
            end
        end
        for (int r = 0; r < int'(v.nres); r++) begin
            e.rng   = v.exp_range[r];
            e.cnt   = v.exp_cnt[r];
            e.err   = v.exp_err[r];
            e.first = ff[r];
            e.lst   = fl[r];
            exp_q.push_back(e);
        end
    endtask

    // Drives stim_q upstream and checks rf_*/res_* against exp_q
    task automatic run_stream(input int err_frame, input int budget);
        int cyc, last_fin, gap_cnt, go_idx, fin_idx, res_idx, viol;
        bit accepted, head_new, prev_go, prev_fin, prev_rv;
        cyc = 0; last_fin = -100; gap_cnt = 0;
        go_idx = 0; fin_idx = 0; res_idx = 0; viol = 0;
        accepted = 1'b0; head_new = 1'b1;
        prev_go = 1'b0; prev_fin = 1'b0; prev_rv = 1'b0;
        while (res_idx < exp_q.size() && cyc < budget) begin
            @(negedge clk);
            cyc++;
            rf_error = 1'b0;
            if (accepted) begin
                void'(stim_q.pop_front());
                head_new = 1'b1;
            end
            if (stim_q.size() > 0 && head_new) begin
                gap_cnt  = int'(stim_q[0].gap);
                head_new = 1'b0;
            end
            if (stim_q.size() > 0 && gap_cnt == 0) begin
                s_valid = 1'b1;
                s_data  = stim_q[0].data;
                s_last  = stim_q[0].last;
            end else begin
                s_valid = 1'b0;
                s_data  = 16'($urandom);
                s_last  = 1'($urandom);
                if (gap_cnt > 0) gap_cnt--;
            end
            accepted = s_valid && s_ready;
            if (s_valid && !s_ready) stalls++;

            if (rf_go && rf_finish) viol++;
            if (rf_go && prev_go) viol++;
            if (rf_finish && prev_fin) viol++;
            if (rf_go) begin
                if (cyc - last_fin < 2) viol++;
                if (go_idx < exp_q.size()) chk("go_data", rf_data, exp_q[go_idx].first);
                else viol++;
                if (go_idx == err_frame) rf_error = 1'b1;
                go_idx++;
            end
            if (rf_finish) begin
                last_fin = cyc;
                if (fin_idx < exp_q.size()) chk("finish_data", rf_data, exp_q[fin_idx].lst);
                else viol++;
                fin_idx++;
            end
            if (res_valid) begin
                if (prev_rv) viol++;
                chk("res_delay", cyc - last_fin, 2);
                chk("res_range", res_range, exp_q[res_idx].rng);
                chk("res_count", res_count, exp_q[res_idx].cnt);
                chk("res_error", res_error, exp_q[res_idx].err);
                res_idx++;
            end
            prev_go  = rf_go;
            prev_fin = rf_finish;
            prev_rv  = res_valid;
        end
        s_valid  = 1'b0;
        rf_error = 1'b0;
        chk("results_received", res_idx, exp_q.size());
        chk("protocol_violations", viol, 0);
    endtask

    vec_t vt [5];

    initial begin
        int   nfr, errf, len;
        int   cnt;
        smp_t s;
        exp_t e;
        logic [15:0] mn, mx, dv;

        for (int i = 0; i < 5; i++) begin
            vt[i] = '0;
            vt[i].err_frame = 2'd3;
        end
        // 5,9,2,7
        vt[0].n = 3'd4; vt[0].d = {16'd0, 16'd0, 16'd7, 16'd2, 16'd9, 16'd5};
        vt[0].last = 6'b001000; vt[0].nres = 2'd1;
        vt[0].exp_range = {16'd0, 16'd7}; vt[0].exp_cnt = {16'd0, 16'd4};
        // single sample 42
        vt[1].n = 3'd1; vt[1].d = {80'd0, 16'd42};
        vt[1].last = 6'b000001; vt[1].nres = 2'd1;
        vt[1].exp_range = {16'd0, 16'd0}; vt[1].exp_cnt = {16'd0, 16'd1};
        // 10,3, gap, 20
        vt[2].n = 3'd3; vt[2].d = {48'd0, 16'd20, 16'd3, 16'd10};
        vt[2].last = 6'b000100; vt[2].gap = 24'h000300; vt[2].nres = 2'd1;
        vt[2].exp_range = {16'd0, 16'd17}; vt[2].exp_cnt = {16'd0, 16'd3};
        // {1,4} then {8,8,8}
        vt[3].n = 3'd5; vt[3].d = {16'd0, 16'd8, 16'd8, 16'd8, 16'd4, 16'd1};
        vt[3].last = 6'b010010; vt[3].nres = 2'd2;
        vt[3].exp_range = {16'd0, 16'd3}; vt[3].exp_cnt = {16'd3, 16'd2};
        // {4,6,1} with rf_error, then clean {2,2}
        vt[4].n = 3'd5; vt[4].d = {16'd0, 16'd2, 16'd2, 16'd1, 16'd6, 16'd4};
        vt[4].last = 6'b010100; vt[4].err_frame = 2'd0; vt[4].nres = 2'd2;
        vt[4].exp_range = {16'd0, 16'd5}; vt[4].exp_cnt = {16'd2, 16'd3};
        vt[4].exp_err = 2'b01;

        n_cmp = 0; n_bad = 0; stalls = 0;
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; rf_error = 1'b0;
        #3;
        chk("reset_outputs", {rf_go, rf_finish, rf_data, res_valid, res_range,
                              res_error, res_count, s_ready}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", s_ready, 1);

        for (int i = 0; i < 5; i++) begin
            load_vec(vt[i]);
            run_stream(int'(vt[i].err_frame), 200);
        end

        // Reset mid-frame with samples in flight
        @(negedge clk); s_valid = 1'b1; s_data = 16'd11; s_last = 1'b0;
        @(negedge clk); s_data = 16'd22;
        @(negedge clk); s_data = 16'd33;
        @(negedge clk); s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midframe_reset_outputs", {rf_go, rf_finish, rf_data, res_valid, res_range,
                                       res_error, res_count, s_ready}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid || rf_go || rf_finish) cnt++;
        end
        chk("no_activity_after_reset", cnt, 0);
        chk("ready_after_midframe_reset", s_ready, 1);
        stim_q.delete(); exp_q.delete();
        s.gap = 4'd0; s.last = 1'b0; s.data = 16'd6; stim_q.push_back(s);
        s.last = 1'b1; s.data = 16'd1; stim_q.push_back(s);
        e.rng = 16'd5; e.cnt = 16'd2; e.err = 1'b0; e.first = 16'd6; e.lst = 16'd1;
        exp_q.push_back(e);
        run_stream(3, 200);

        // Randomized frames against the frame-level model
        stim_q.delete(); exp_q.delete(); stalls = 0;
        nfr  = 40;
        errf = int'($urandom_range(0, nfr - 1));
        for (int f = 0; f < nfr; f++) begin
            len = int'($urandom_range(1, 5));
            mn  = 16'hFFFF;
            mx  = 16'h0000;
            for (int i = 0; i < len; i++) begin
                dv     = 16'($urandom);
                s.data = dv;
                s.last = (i == len - 1);
                s.gap  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 3)) : 4'd0;
                stim_q.push_back(s);
                if (dv < mn) mn = dv;
                if (dv > mx) mx = dv;
                if (i == 0) e.first = dv;
                e.lst = dv;
            end
            e.rng = mx - mn;
            e.cnt = 16'(len);
            e.err = (f == errf);
            exp_q.push_back(e);
        end
        run_stream(errf, 3000);
        chk("ready_backpressure_seen", (stalls > 0) ? 1 : 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
